pwm_duty_meter: RTL and testbench



---
 rtl/pwm_pkg.sv | 15 +
 rtl/pwm_in_sync.sv | 36 +++
 rtl/pwm_duty_meter.sv | 173 +++++++++++++++++
 tb/tb_pwm_duty_meter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared PWM constants and types (generator and duty meter).
// Latency: n/a (package only).
// Backpressure: n/a.
package pwm_pkg;

  localparam int DUTY_STEPS = 10;  // duty resolution: 10% steps, 0..10
  localparam int DUTY_W     = 4;   // bits needed to hold 0..DUTY_STEPS
  localparam int DIV_ITERS  = 4;   // restoring-divider iterations (one quotient bit each)

  typedef enum logic {
    SEEK,
    MEAS
  } pwm_state_t;

endpackage

// File: rtl/pwm_in_sync.sv
// Synchronizes an asynchronous PWM line and flags its rising edge.
// Latency: SYNC_STAGES cycles to o_pwm_s; o_rise is combinational on the synced line.
// Backpressure: none, free-running.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_pwm      : raw asynchronous PWM line
//   o_pwm_s    : synchronized line
//   o_rise     : high for one cycle, the cycle after o_pwm_s goes 0->1
module pwm_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_pwm,
  output logic o_pwm_s,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_pwm_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= '0;
      r_pwm_d <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], i_pwm};
      r_pwm_d <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_pwm_s = r_sync[SYNC_STAGES-1];
  assign o_rise  = o_pwm_s & ~r_pwm_d;

endmodule

// File: rtl/pwm_duty_meter.sv
// Measures period, high time and 10%-step duty of an incoming PWM line.
// Latency: rising edge detect -> meas_valid = 5 cycles (4-step divider).
// Backpressure: none; a period ending while the divider is busy is dropped and flagged on overrun.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   pwm_in      : PWM line, asynchronous to clk
//   period_out  : last period, clk cycles rise-to-rise (0 on a stuck report)
//   high_out    : last high time, clk cycles (0 on a stuck report)
//   duty_out    : round(high*10/period), 0..10
//   meas_valid  : 1-cycle strobe, outputs above updated
//   stuck       : level, no rising edge within TIMEOUT cycles
//   overrun     : 1-cycle strobe, sample dropped because the divider was busy
module pwm_duty_meter
  import pwm_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int TIMEOUT     = 1000,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pwm_in,
  output logic [CNT_W-1:0]  period_out,
  output logic [CNT_W-1:0]  high_out,
  output logic [DUTY_W-1:0] duty_out,
  output logic              meas_valid,
  output logic              stuck,
  output logic              overrun
);

  localparam int NUM_W = CNT_W + 4;
  localparam logic [CNT_W-1:0]  TMO_CNT  = CNT_W'(TIMEOUT);
  localparam logic [DUTY_W-1:0] DUTY_MAX = DUTY_W'(DUTY_STEPS);
  localparam logic [1:0]        LAST_IT  = 2'(DIV_ITERS - 1);

  logic w_pwm_s;
  logic w_rise;

  pwm_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_pwm   (pwm_in),
    .o_pwm_s (w_pwm_s),
    .o_rise  (w_rise)
  );

  pwm_state_t        r_state;
  logic [CNT_W-1:0]  r_period_cnt;
  logic [CNT_W-1:0]  r_high_cnt;
  logic              r_busy;
  logic [1:0]        r_iter;
  logic [NUM_W-1:0]  r_rem;
  logic [CNT_W-1:0]  r_div;       // snapshot period, also the divisor
  logic [CNT_W-1:0]  r_snap_high;
  logic [DUTY_W-1:0] r_quo;

  logic              w_tmo;
  logic [NUM_W-1:0]  w_num;
  logic [1:0]        w_sh;
  logic [NUM_W-1:0]  w_sub;
  logic              w_ge;
  logic [NUM_W-1:0]  w_rem_nxt;
  logic [DUTY_W-1:0] w_quo_nxt;
  logic [DUTY_W-1:0] w_duty;

  // Counters saturate here; also the stuck threshold.
  assign w_tmo = (r_period_cnt == TMO_CNT);

  // Adding period/2 before the divide turns truncation into round-half-up.
  assign w_num = ({4'b0, r_period_cnt} >> 1)
               + ({4'b0, r_high_cnt} * NUM_W'(DUTY_STEPS));

  // MSB-first restoring division. high <= period keeps N < 16*period,
  // so four quotient bits always suffice.
  assign w_sh      = LAST_IT - r_iter;
  assign w_sub     = {4'b0, r_div} << w_sh;
  assign w_ge      = (r_rem >= w_sub);
  assign w_rem_nxt = w_ge ? (r_rem - w_sub) : r_rem;

  always_comb begin
    w_quo_nxt       = r_quo;
    w_quo_nxt[w_sh] = w_ge;
  end

  assign w_duty = (w_quo_nxt > DUTY_MAX) ? DUTY_MAX : w_quo_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= SEEK;
      r_period_cnt <= '0;
      r_high_cnt   <= '0;
      r_busy       <= 1'b0;
      r_iter       <= '0;
      r_rem        <= '0;
      r_div        <= '0;
      r_snap_high  <= '0;
      r_quo        <= '0;
      period_out   <= '0;
      high_out     <= '0;
      duty_out     <= '0;
      meas_valid   <= 1'b0;
      stuck        <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      overrun    <= 1'b0;

      // The rise cycle is cycle 1 of the new period, and pwm_s is high in it.
      if (w_rise) begin
        r_period_cnt <= CNT_W'(1);
        r_high_cnt   <= CNT_W'(1);
      end else if (!w_tmo) begin
        r_period_cnt <= r_period_cnt + CNT_W'(1);
        if (w_pwm_s) r_high_cnt <= r_high_cnt + CNT_W'(1);
      end

      // Divider runs beside the counters; the result loads with the strobe.
      if (r_busy) begin
        r_rem  <= w_rem_nxt;
        r_quo  <= w_quo_nxt;
        r_iter <= r_iter + 2'd1;
        if (r_iter == LAST_IT) begin
          r_busy     <= 1'b0;
          meas_valid <= 1'b1;
          period_out <= r_div;
          high_out   <= r_snap_high;
          duty_out   <= w_duty;
        end
      end

      case (r_state)
        SEEK: begin
          // Partial first period yields no result; just arm on the first rise.
          if (w_rise) begin
            r_state <= MEAS;
            stuck   <= 1'b0;
          end else if (w_tmo && !stuck) begin
            stuck      <= 1'b1;
            meas_valid <= 1'b1;
            period_out <= '0;
            high_out   <= '0;
            duty_out   <= w_pwm_s ? DUTY_MAX : '0;
          end
        end
        MEAS: begin
          if (w_rise) begin
            if (r_busy) begin
              overrun <= 1'b1;
            end else begin
              r_busy      <= 1'b1;
              r_iter      <= '0;
              r_quo       <= '0;
              r_rem       <= w_num;
              r_div       <= r_period_cnt;
              r_snap_high <= r_high_cnt;
            end
          end else if (w_tmo) begin
            // Line idles at 0% or 100%: report its level as the duty.
            r_state    <= SEEK;
            stuck      <= 1'b1;
            meas_valid <= 1'b1;
            period_out <= '0;
            high_out   <= '0;
            duty_out   <= w_pwm_s ? DUTY_MAX : '0;
          end
        end
        default: r_state <= SEEK;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Directed bench for pwm_duty_meter with hand-computed expectations.
// Input edges are driven just after a falling clock edge; outputs sampled 1ns after rising edges.
// Strobes and overruns are logged by a monitor and checked after each phase.
module tb_pwm_duty_meter;

  localparam int CNT_W = 16;
  localparam int TMO   = 100;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              pwm_in;
  logic [CNT_W-1:0]  period_out;
  logic [CNT_W-1:0]  high_out;
  logic [3:0]        duty_out;
  logic              meas_valid;
  logic              stuck;
  logic              overrun;

  always #5 clk = ~clk;

  pwm_duty_meter #(.CNT_W(CNT_W), .TIMEOUT(TMO), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pwm_in     (pwm_in),
    .period_out (period_out),
    .high_out   (high_out),
    .duty_out   (duty_out),
    .meas_valid (meas_valid),
    .stuck      (stuck),
    .overrun    (overrun)
  );

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int ovr_cnt = 0;
  int q_cyc[$];
  int q_per[$];
  int q_high[$];
  int q_duty[$];
  int q_stk[$];
  int q_rise[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (meas_valid === 1'b1) begin
      q_cyc.push_back(cyc);
      q_per.push_back(int'(period_out));
      q_high.push_back(int'(high_out));
      q_duty.push_back(int'(duty_out));
      q_stk.push_back(int'(stuck));
    end
    if (overrun === 1'b1) ovr_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    q_cyc.delete(); q_per.delete(); q_high.delete();
    q_duty.delete(); q_stk.delete(); q_rise.delete();
    ovr_cnt = 0;
  endtask

  // Called right after a falling edge; one full PWM period starting with a rise.
  task automatic pwm_period(input int per, input int hi);
    pwm_in = 1'b1;
    q_rise.push_back(cyc);
    repeat (hi) @(negedge clk);
    pwm_in = 1'b0;
    repeat (per - hi) @(negedge clk);
  endtask

  task automatic train(input int per, input int hi, input int n);
    for (int i = 0; i < n; i++) pwm_period(per, hi);
  endtask

  int r_rel, k1, rr;

  initial begin
    rst_n  = 1'b0;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_period", 32'(period_out), 0);
    chk("rst_high",   32'(high_out),   0);
    chk("rst_duty",   32'(duty_out),   0);
    chk("rst_valid",  32'(meas_valid), 0);
    chk("rst_stuck",  32'(stuck),      0);

    // Constant low from reset: single stuck report after TIMEOUT cycles.
    clr();
    rst_n = 1'b1;
    r_rel = cyc;
    repeat (150) @(negedge clk);
    chk("low_nstrobe", q_cyc.size(), 1);
    chk("low_tmo_cyc", q_cyc[0], r_rel + 101);
    chk("low_stk",     q_stk[0], 1);
    chk("low_per",     q_per[0], 0);
    chk("low_high",    q_high[0], 0);
    chk("low_duty",    q_duty[0], 0);
    repeat (100) @(negedge clk);
    chk("low_single",  q_cyc.size(), 1);
    chk("low_stuck_lvl", 32'(stuck), 1);

    // Pulse train 10/5: stuck clears on the rise, first result after the second rise.
    clr();
    pwm_in = 1'b1;
    k1 = cyc;
    repeat (2) @(negedge clk);
    chk("clr_stuck_hold", 32'(stuck), 1);
    repeat (2) @(negedge clk);
    chk("clr_stuck", 32'(stuck), 0);
    repeat (1) @(negedge clk);
    pwm_in = 1'b0;
    repeat (5) @(negedge clk);
    train(10, 5, 4);
    chk("t1_nstrobe", q_cyc.size(), 4);
    chk("t1_first_cyc", q_cyc[0], q_rise[0] + 7);
    chk("t1_per",  q_per[0], 10);
    chk("t1_high", q_high[0], 5);
    chk("t1_duty", q_duty[0], 5);
    chk("t1_stk",  q_stk[0], 0);
    for (int i = 1; i < 4; i++) chk("t1_gap", q_cyc[i] - q_cyc[i-1], 10);

    // Duty steps 6..9 at period 10, then constant high.
    for (int d = 6; d < 10; d++) begin
      clr();
      train(10, d, 3);
      chk("step_high", q_high[$], d);
      chk("step_duty", q_duty[$], d);
      chk("step_per",  q_per[$], 10);
    end
    clr();
    pwm_in = 1'b1;
    rr = cyc;
    repeat (200) @(negedge clk);
    chk("hi_nstrobe", q_cyc.size(), 2);
    chk("hi_last9",   q_duty[0], 9);
    chk("hi_tmo_cyc", q_cyc[1], rr + 103);
    chk("hi_stk",     q_stk[1], 1);
    chk("hi_per",     q_per[1], 0);
    chk("hi_high",    q_high[1], 0);
    chk("hi_duty",    q_duty[1], 10);
    chk("hi_stuck_lvl", 32'(stuck), 1);

    // Rounding cases and minimum period.
    pwm_in = 1'b0;
    repeat (5) @(negedge clk);
    clr();
    train(12, 7, 3);
    chk("rnd_stuck_clr", 32'(stuck), 0);
    chk("rnd12_per",  q_per[$], 12);
    chk("rnd12_high", q_high[$], 7);
    chk("rnd12_duty", q_duty[$], 6);
    clr();
    train(20, 1, 3);
    chk("rnd20_per",  q_per[$], 20);
    chk("rnd20_duty", q_duty[$], 1);
    clr();
    train(21, 1, 3);
    chk("rnd21_per",  q_per[$], 21);
    chk("rnd21_duty", q_duty[$], 0);
    clr();
    train(5, 2, 3);
    repeat (5) @(negedge clk);
    chk("min5_nstrobe", q_cyc.size(), 3);
    chk("min5_per",  q_per[$], 5);
    chk("min5_high", q_high[$], 2);
    chk("min5_duty", q_duty[$], 4);
    chk("min5_ovr",  ovr_cnt, 0);

    // Period 4: every other rise lands while the divider is busy.
    train(10, 5, 2);
    clr();
    train(4, 2, 8);
    repeat (20) @(negedge clk);
    chk("ovr_cnt",     ovr_cnt, 4);
    chk("ovr_nstrobe", q_cyc.size(), 4);
    chk("ovr_first_per", q_per[0], 10);
    chk("ovr_per",  q_per[$], 4);
    chk("ovr_high", q_high[$], 2);
    chk("ovr_duty", q_duty[$], 5);
    chk("ovr_hold_per", 32'(period_out), 4);

    // Reset mid-measurement with the divider busy.
    train(10, 5, 2);
    pwm_in = 1'b1;
    repeat (4) @(negedge clk);
    chk("pre_rst_per", 32'(period_out), 10);
    clr();
    rst_n = 1'b0;
    #1;
    chk("mrst_per",   32'(period_out), 0);
    chk("mrst_high",  32'(high_out),   0);
    chk("mrst_duty",  32'(duty_out),   0);
    chk("mrst_valid", 32'(meas_valid), 0);
    pwm_in = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("mrst_nostrobe", q_cyc.size(), 0);
    train(10, 5, 3);
    chk("post_nstrobe", q_cyc.size(), 2);
    chk("post_first_cyc", q_cyc[0], q_rise[1] + 7);
    chk("post_per",  q_per[0], 10);
    chk("post_duty", q_duty[0], 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
